// File: rtl/pipe_hazard_ctrl_if.sv
// Control bundle between the pipeline hazard sequencer and the datapath stages.
// The master side supplies the stall/hazard/redirect sources; the slave side returns the stage controls.
interface pipe_hazard_ctrl_if;
  logic        Istall;
  logic        Dstall;
  logic [4:0]  rs1_addr_ID;
  logic [4:0]  rs2_addr_ID;
  logic        rs1_used_ID;
  logic        rs2_used_ID;
  logic [4:0]  write_addr_EXE;
  logic        mem_read_EXE;
  logic        branch_taken_EXE;
  logic        jalr_EXE;
  logic [31:0] target_EXE;
  logic        cnt_clr;

  logic        pipe_stall;
  logic        pc_write;
  logic        IF_ID_write;
  logic        flush;
  logic        flush_jalr;
  logic        lu_bubble;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] stall_cycles;
  logic [15:0] redirect_cnt;

  modport master (
    output Istall, Dstall, rs1_addr_ID, rs2_addr_ID, rs1_used_ID, rs2_used_ID,
           write_addr_EXE, mem_read_EXE, branch_taken_EXE, jalr_EXE, target_EXE, cnt_clr,
    input  pipe_stall, pc_write, IF_ID_write, flush, flush_jalr, lu_bubble,
           redirect_valid, redirect_pc, stall_cycles, redirect_cnt
  );

  modport slave (
    input  Istall, Dstall, rs1_addr_ID, rs2_addr_ID, rs1_used_ID, rs2_used_ID,
           write_addr_EXE, mem_read_EXE, branch_taken_EXE, jalr_EXE, target_EXE, cnt_clr,
    output pipe_stall, pc_write, IF_ID_write, flush, flush_jalr, lu_bubble,
           redirect_valid, redirect_pc, stall_cycles, redirect_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: memory stalls, load-use bubbles and EXE redirects, with a
// redirect that resolves under a stall parked in PEND and replayed once the stall clears.
module pipe_hazard_ctrl (
  input  logic               clk,
  input  logic               rst,
  pipe_hazard_ctrl_if.slave  hz
);
  localparam int data_size = 32;

  typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_t;

  state_t                 state_r, state_nxt;
  logic [data_size-1:0]   pend_tgt_r, pend_tgt_nxt;
  logic                   pend_jalr_r, pend_jalr_nxt;
  logic [31:0]            stall_cycles_r;
  logic [15:0]            redirect_cnt_r;

  logic                   mem_stall;
  logic                   live_redir;
  logic                   hazard;
  logic                   redir;
  logic                   redir_jalr;
  logic [data_size-1:0]   redir_pc;
  logic                   redir_act;
  logic                   lu_act;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign mem_stall  = hz.Istall | hz.Dstall;
  assign live_redir = hz.branch_taken_EXE | hz.jalr_EXE;

  always_comb begin
    hazard = 1'b0;
    if (hz.mem_read_EXE && (hz.write_addr_EXE != 5'd0)) begin
      hazard = (hz.rs1_used_ID && (hz.rs1_addr_ID == hz.write_addr_EXE)) ||
               (hz.rs2_used_ID && (hz.rs2_addr_ID == hz.write_addr_EXE));
    end
  end

  always_comb begin
    state_nxt     = state_r;
    pend_tgt_nxt  = pend_tgt_r;
    pend_jalr_nxt = pend_jalr_r;
    redir         = 1'b0;
    redir_jalr    = 1'b0;
    redir_pc      = '0;
    case (state_r)
      IDLE: begin
        if (live_redir) begin
          if (mem_stall) begin
            state_nxt     = PEND;
            pend_tgt_nxt  = hz.target_EXE;
            pend_jalr_nxt = hz.jalr_EXE;
          end else begin
            redir      = 1'b1;
            redir_pc   = hz.target_EXE;
            redir_jalr = hz.jalr_EXE;
          end
        end
      end
      // Live EXE inputs belong to the held instruction here, so they are ignored.
      PEND: begin
        if (!mem_stall) begin
          state_nxt  = IDLE;
          redir      = 1'b1;
          redir_pc   = pend_tgt_r;
          redir_jalr = pend_jalr_r;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are pinned to their inert values while reset is held.
  assign redir_act = rst & redir;
  assign lu_act    = rst & hazard & ~mem_stall & ~redir;

  assign hz.pipe_stall     = mem_stall;
  assign hz.redirect_valid = redir_act;
  assign hz.redirect_pc    = redir_act ? redir_pc : '0;
  assign hz.flush_jalr     = redir_act & redir_jalr;
  assign hz.flush          = redir_act & ~redir_jalr;
  assign hz.lu_bubble      = lu_act;
  assign hz.pc_write       = ~rst | redir_act | (~mem_stall & ~lu_act);
  assign hz.IF_ID_write    = ~rst | (~mem_stall & ~lu_act);
  assign hz.stall_cycles   = stall_cycles_r;
  assign hz.redirect_cnt   = redirect_cnt_r;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      pend_tgt_r  <= '0;
      pend_jalr_r <= 1'b0;
    end else begin
      state_r     <= state_nxt;
      pend_tgt_r  <= pend_tgt_nxt;
      pend_jalr_r <= pend_jalr_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles_r <= '0;
      redirect_cnt_r <= '0;
    end else if (hz.cnt_clr) begin
      stall_cycles_r <= '0;
      redirect_cnt_r <= '0;
    end else begin
      if (mem_stall | lu_act) stall_cycles_r <= sat_inc32(stall_cycles_r);
      if (redir_act)          redirect_cnt_r <= redirect_cnt_r + 16'd1;
    end
  end
endmodule
